icache: RTL
===========

# icache

Direct-mapped, read-only L1 instruction cache between the pipeline's fetch port (imemREN/imemaddr/ihit/imemload) and the memory controller's instruction port (iREN/iaddr/iwait/iload). Serves each fetch in the same cycle on a hit. On a miss it fills a two-word block from memory with a small FSM, then returns a hit. The pipeline stalls on !ihit, so fetch address stability during a fill is guaranteed by the consumer.

## Interface
Parameters:
- SETS, 8, number of frames (power of two, ≥2)
- WORD_W, 32, data/address width

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- imemREN  in  1  fetch request from datapath
- imemaddr  in  32  fetch byte address, word aligned ([1:0] ignored)
- ihit  out  1  imemload valid this cycle
- imemload  out  32  fetched instruction
- iREN  out  1  read request to memory controller
- iaddr  out  32  memory read byte address
- iwait  in  1  memory not ready; iload valid when iREN && !iwait
- iload  in  32  memory read data
- inval  in  1  invalidate all frames
- hit_count  out  32  hit counter (see Configuration)
- miss_count  out  32  miss counter (see Configuration)

## Operation
- Address split with SETS=8: [1:0] byte, [2] block offset, [5:3] index, [31:6] tag (26 b); index width = log2(SETS), tag = 32−3−log2(SETS).
- Per frame: valid bit, tag, data[0:1].
- Hit (combinational): state==IDLE && imemREN && !inval && valid[idx] && tag match; imemload = data[idx][offset]. imemload = 0 whenever ihit=0.
- FSM states IDLE, FILL0, FILL1:
  - IDLE: imemREN && !hit && !inval → FILL0, latching miss tag/index.
  - FILL0: iREN=1, iaddr={tag,idx,1'b0,2'b00}; on !iwait store iload to data[0] → FILL1.
  - FILL1: iREN=1, iaddr=FILL0 address+4; on !iwait store iload to data[1], write tag, set valid → IDLE.
- Fill address uses the latched miss tag/index, not live imemaddr; a fill always completes once started, even if imemREN drops.
- inval: all valid bits cleared at the next edge; in FILL0/FILL1, abort the fill (no tag/valid write) and go to IDLE. inval has priority over fill completion in the same cycle.
- iREN=0 and iaddr=0 in IDLE.

## Timing
- Reset (RST high at edge): all valid=0, state=IDLE. Outputs after reset: ihit=0, imemload=0, iREN=0, iaddr=0, hit_count=0, miss_count=0.
- Hit latency: 0 cycles (same-cycle ihit).
- Miss with zero-wait memory: miss detected cycle 0 → FILL0 cycle 1 → FILL1 cycle 2 → ihit cycle 3. Each iwait cycle adds one.
- Fetch of the other word in a just-filled block hits with no memory access.
- Conflict (same index, different tag): the new fill overwrites the frame.
- RST mid-fill: same as reset; no partial frame left valid.

## Configuration
- ICACHE_STATS_EN defined: hit_count increments on each cycle with ihit=1; miss_count increments on each IDLE→FILL0 transition. Both wrap at 2^32, clear on RST, and are not cleared by inval.
- ICACHE_STATS_EN undefined: no counter registers; hit_count and miss_count tied to 0.

## Test plan
- Cold miss: reset, imemREN=1, imemaddr=0x40, iwait=0, memory[0x40]=0xAAAA0001, [0x44]=0xBBBB0002 → iaddr 0x40 then 0x44, ihit=1 with imemload=0xAAAA0001 in cycle 3; then imemaddr=0x44 → same-cycle ihit, 0xBBBB0002, no iREN.
- Wait states: repeat cold miss with iwait=1 for 3 cycles per access → ihit in cycle 9; iaddr held stable while iwait=1.
- Conflict: fill 0x40, then fetch 0x440 (same index 0) → miss, refill; fetch 0x40 again → miss.
- inval mid-fill: inval=1 during FILL1 → return to IDLE, frame invalid, next fetch of 0x40 misses and restarts at FILL0.
- Reset mid-fill: RST=1 during FILL0 → iREN=0 next cycle, all outputs at reset values, next fetch misses.
- Stats (ICACHE_STATS_EN): cold miss plus 4 hits → miss_count=1, hit_count=4; after inval, counts are unchanged. Without the macro, both counters read 0.

Source files
------------

// File: rtl/icache.sv
`timescale 1ns/1ps
// icache: direct-mapped read-only L1 instruction cache with two-word blocks and a 3-state fill FSM.
// Define ICACHE_STATS_EN to build the hit/miss counters; without it both counter outputs read 0.
module icache #(
    parameter int SETS   = 8,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload,
    input  logic              inval,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WORD_W - 3 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL0, FILL1} state_t;

    state_t            state, next_state;
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags  [SETS];
    logic [WORD_W-1:0] data0 [SETS];
    logic [WORD_W-1:0] data1 [SETS];

    logic [TAG_W-1:0]  miss_tag;
    logic [IDX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic              req_off;
    logic              lookup_hit;
    logic              start_fill;
    logic              wr_word0;
    logic              wr_word1;
    logic              unused_bits;

    assign req_tag     = imemaddr[WORD_W-1 -: TAG_W];
    assign req_idx     = imemaddr[3 +: IDX_W];
    assign req_off     = imemaddr[2];
    assign unused_bits = ^imemaddr[1:0];

    assign lookup_hit = valid[req_idx] && (tags[req_idx] == req_tag);
    assign ihit       = (state == IDLE) && imemREN && !inval && lookup_hit;
    assign imemload   = ihit ? (req_off ? data1[req_idx] : data0[req_idx]) : '0;
    assign start_fill = (state == IDLE) && imemREN && !inval && !lookup_hit;

    // inval (and RST) suppress every array write so an aborted fill leaves nothing behind
    assign wr_word0 = (state == FILL0) && !iwait && !inval && !RST;
    assign wr_word1 = (state == FILL1) && !iwait && !inval && !RST;

    always_comb begin
        next_state = state;
        iREN       = 1'b0;
        iaddr      = '0;
        case (state)
            IDLE: begin
                if (start_fill) next_state = FILL0;
            end
            FILL0: begin
                iREN  = 1'b1;
                iaddr = {miss_tag, miss_idx, 3'b000};
                if (inval)       next_state = IDLE;
                else if (!iwait) next_state = FILL1;
            end
            FILL1: begin
                iREN  = 1'b1;
                iaddr = {miss_tag, miss_idx, 3'b100};
                if (inval || !iwait) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            valid    <= '0;
            miss_tag <= '0;
            miss_idx <= '0;
        end else begin
            state <= next_state;
            if (inval)         valid           <= '0;
            else if (wr_word1) valid[miss_idx] <= 1'b1;
            if (start_fill) begin
                miss_tag <= req_tag;
                miss_idx <= req_idx;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_word0) data0[miss_idx] <= iload;
        if (wr_word1) begin
            data1[miss_idx] <= iload;
            tags[miss_idx]  <= miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (ihit)       hit_q  <= hit_q + 32'd1;
            if (start_fill) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
